uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver for 8N1 frames at 115200 baud, LSB first. Runs on the 50 MHz system clock and uses the one-cycle 16x-oversample tick from the baud generator. It synchronises the asynchronous serial line, validates start and stop bits at mid-bit, and presents each received byte with a one-cycle strobe. Sits between the board RX pin and the byte-level consumer (command parser or FIFO).

## Interface
Parameters:
- `OVERSAMPLE`, 16: `rx_clk` ticks per bit; power of two, ≥4.
- `DATA_BITS`, 8: payload bits per frame.

Ports:
- `clk50`  in  1  50 MHz system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_clk`  in  1  oversample tick; high for one `clk50` cycle every 27 cycles.
- `rx`  in  1  asynchronous serial line; idles high.
- `data`  out  DATA_BITS  last good byte; reset 0; updated only with `valid`.
- `valid`  out  1  one-cycle pulse when a frame with a good stop bit completes; reset 0.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples 0; reset 0.
- `busy`  out  1  high in any state other than IDLE; reset 0.

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1) to give `rx_s`. All sampling uses `rx_s`.
- State and counters advance only on `clk50` cycles with `rx_clk`=1. Otherwise everything holds, except that `valid` and `frame_err` drop.
- Registers:
  - `cnt`: log2(OVERSAMPLE) bits.
  - `bit_idx`: counts 0..DATA_BITS-1.
  - `shift`: DATA_BITS bits.
  - `armed`: 1 bit.
- Arming:
  - `armed` is set on any tick where `rx_s`=1 in IDLE.
  - `armed` is cleared on reset and on exit from STOP.
  - The line must therefore be seen high before a new start is accepted, so a held-low break yields exactly one frame.
- IDLE:
  - On a tick with `armed`=1 and `rx_s`=0: go to START, `cnt`←0.
- START:
  - Each tick: `cnt`++.
  - On the tick where `cnt`=OVERSAMPLE/2−1 (mid start bit):
    - `rx_s`=0: go to DATA, `cnt`←0, `bit_idx`←0.
    - `rx_s`=1: glitch; go to IDLE, no outputs.
- DATA:
  - Each tick: `cnt`++, wrapping at OVERSAMPLE.
  - On the tick where `cnt`=OVERSAMPLE−1: `shift`←{`rx_s`, `shift`[DATA_BITS−1:1]}, so the first bit lands in bit 0 after the last shift.
  - After shifting bit DATA_BITS−1: go to STOP, else `bit_idx`++.
- STOP:
  - On the tick where `cnt`=OVERSAMPLE−1:
    - `rx_s`=1: `data`←`shift`, `valid`←1.
    - `rx_s`=0: `frame_err`←1; `data` unchanged.
  - In both cases: go to IDLE, `armed`←0.
- Back-to-back frames: the STOP sample of `rx_s`=1 arms the receiver at the next IDLE tick, so a start bit right after a stop bit is accepted with no idle gap required.
- Reset mid-frame:
  - Immediate return to IDLE; all outputs 0, synchroniser 1, `armed` 0.
  - No strobe for the partial frame.

## Timing
- Input to `rx_s`: 2 `clk50` cycles.
- Start detection: up to 1 tick of jitter (≤27 cycles), well inside the half-bit margin.
- Sampling points (ticks after the detect tick):
  - Start check: OVERSAMPLE/2 (8).
  - Data bit k: 8+16(k+1).
  - Stop bit: 8+16·9 = 152.
- `valid` / `frame_err`:
  - Asserted the `clk50` cycle after the stop-sample tick.
  - High exactly one cycle; never both high together.
- `busy`: registered with the state.
- Baud error: 50e6/27/16 = 115741 baud (+0.47%), tolerated.

## Structure
- Package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP);
  - `UART_OVERSAMPLE`=16, `UART_DATA_BITS`=8;
  - `UART_MID`=OVERSAMPLE/2−1.
- The baud generator shares `uart_pkg`, and a later transmitter will too.
- One sub-module: `sync_2ff` (parameterised reset value), reused for other asynchronous inputs.

## Test plan
- Byte 0xA5 sent at 115200 with stop=1 → one `valid` pulse, `data`=0xA5, `frame_err`=0, `busy` low after the stop sample.
- `rx` low for 4 ticks then high → no `valid` or `frame_err`; `busy` returns to 0 at the mid-start check.
- Byte 0x3C with stop=0, after a prior 0xA5 → one `frame_err` pulse, `data` stays 0xA5, no `valid`.
- 0x00 then 0xFF with zero idle between frames → two `valid` pulses, `data` 0x00 then 0xFF.
- `rst` asserted after 3 data bits of 0x96, then 0x5A sent → outputs 0 during reset, no strobe for 0x96, then `valid` with `data`=0x5A.
- `rx` held low for 30 bit times, then high, then 0x11 sent → exactly one `frame_err`, no further strobes while low, then `valid` with `data`=0x11.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver/transmitter/baud-generator types and constants
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_MID = UART_OVERSAMPLE / 2 - 1;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit input
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;
  // shift the raw input through two flops to settle metastability
  always_ff @(posedge clk_i)
    sync_q <= rst_i ? {2{RST_VAL}} : {sync_q[0], d_i};
  assign q_o = sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 oversampling UART receiver with mid-bit start/stop validation
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk50,
  input  logic                 rst,
  input  logic                 rx_clk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic armed_q, armed_d, valid_q, valid_d, ferr_q, ferr_d;
  logic rx_s;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk_i(clk50),
    .rst_i(rst),
    .d_i  (rx),
    .q_o  (rx_s)
  );
  // next state: everything holds between ticks, strobes drop every non-stop cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    armed_d   = armed_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    if (rx_clk) begin
      case (state_q)
        IDLE: begin
          if (rx_s) armed_d = 1'b1;
          else if (armed_q) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == MID) begin
            state_d   = rx_s ? IDLE : DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
          end
        end
        DATA: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
            state_d   = bit_idx_q == LAST_BIT ? STOP : DATA;
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
        STOP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = IDLE;
            armed_d = 1'b0;
            data_d  = rx_s ? shift_q : data_q;
            valid_d = rx_s;
            ferr_d  = ~rx_s;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // state and output registers with synchronous reset
  always_ff @(posedge clk50) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      armed_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      armed_q   <= armed_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end
  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;
  localparam int BIT_CYC = 434;
  logic clk50 = 0, rst = 1, rx_clk = 0, rx = 1;
  logic [7:0] data;
  logic valid, frame_err, busy;
  int checks = 0, errors = 0;
  int fe_cnt = 0, exp_fe = 0, bad_pulse = 0;
  logic prev_v = 0, prev_f = 0;
  logic [7:0] last_good = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  uart_rx dut (
    .clk50(clk50), .rst(rst), .rx_clk(rx_clk), .rx(rx),
    .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
  );
  always #10 clk50 = ~clk50;
  initial forever begin
    repeat (26) @(negedge clk50);
    rx_clk = 1;
    @(negedge clk50);
    rx_clk = 0;
  end
  always @(negedge clk50) begin
    if (valid) got_q.push_back(data);
    if (frame_err) fe_cnt++;
    if ((valid && frame_err) || (valid && prev_v) || (frame_err && prev_f)) bad_pulse++;
    prev_v = valid;
    prev_f = frame_err;
  end
  function automatic bit streams_equal();
    if (got_q.size() != exp_q.size()) return 0;
    foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return 0;
    return 1;
  endfunction
  task automatic clear();
    got_q.delete();
    exp_q.delete();
    fe_cnt = 0;
    exp_fe = 0;
  endtask
  task automatic idle(input int bits);
    rx = 1;
    repeat (bits * BIT_CYC) @(negedge clk50);
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (BIT_CYC) @(negedge clk50);
    end
    if (stop) begin
      exp_q.push_back(b);
      last_good = b;
    end else exp_fe++;
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (5) @(negedge clk50);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 0;
    idle(2);
  endtask
  task automatic test_good();
    clear();
    send_frame(8'hA5, 1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy got %b want 0", busy); end
    idle(1);
    checks++; if (!streams_equal()) begin errors++; $display("FAIL good_stream got %0d bytes want %0d", got_q.size(), exp_q.size()); end
    checks++; if (fe_cnt != exp_fe) begin errors++; $display("FAIL good_ferr got %0d want %0d", fe_cnt, exp_fe); end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL good_data got %h want a5", data); end
  endtask
  task automatic test_glitch();
    clear();
    rx = 0;
    repeat (4 * 27) @(negedge clk50);
    rx = 1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi got %b want 1", busy); end
    repeat (12 * 27) @(negedge clk50);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_lo got %b want 0", busy); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL glitch_valid got %0d want 0", got_q.size()); end
    checks++; if (fe_cnt != 0) begin errors++; $display("FAIL glitch_ferr got %0d want 0", fe_cnt); end
    idle(1);
  endtask
  task automatic test_frame_error();
    clear();
    send_frame(8'hA5, 1);
    idle(1);
    send_frame(8'h3C, 0);
    idle(1);
    checks++; if (!streams_equal()) begin errors++; $display("FAIL ferr_stream got %0d bytes want %0d", got_q.size(), exp_q.size()); end
    checks++; if (fe_cnt != exp_fe) begin errors++; $display("FAIL ferr_count got %0d want %0d", fe_cnt, exp_fe); end
    checks++; if (data !== last_good) begin errors++; $display("FAIL ferr_data got %h want %h", data, last_good); end
    checks++; if (bad_pulse != 0) begin errors++; $display("FAIL ferr_pulse got %0d want 0", bad_pulse); end
  endtask
  task automatic test_back_to_back();
    clear();
    send_frame(8'h00, 1);
    send_frame(8'hFF, 1);
    send_frame(8'($urandom), 1);
    idle(1);
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", got_q.size()); end
    checks++; if (!streams_equal()) begin errors++; $display("FAIL b2b_stream got %h want %h", got_q.size() > 1 ? got_q[1] : 8'h00, exp_q[1]); end
    checks++; if (data !== last_good) begin errors++; $display("FAIL b2b_data got %h want %h", data, last_good); end
    checks++; if (fe_cnt != 0) begin errors++; $display("FAIL b2b_ferr got %0d want 0", fe_cnt); end
  endtask
  task automatic test_reset_mid();
    logic [3:0] part;
    clear();
    part = {3'b110, 1'b0};
    for (int i = 0; i < 4; i++) begin
      rx = part[i];
      repeat (BIT_CYC) @(negedge clk50);
    end
    rst = 1;
    rx = 1;
    repeat (3) @(negedge clk50);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL rmid_data got %h want 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rmid_ferr got %b want 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    repeat (3) @(negedge clk50);
    rst = 0;
    last_good = 0;
    idle(2);
    checks++; if (got_q.size() != 0 || fe_cnt != 0) begin errors++; $display("FAIL rmid_partial got %0d strobes want 0", got_q.size() + fe_cnt); end
    send_frame(8'h5A, 1);
    idle(1);
    checks++; if (!streams_equal()) begin errors++; $display("FAIL rmid_stream got %0d bytes want %0d", got_q.size(), exp_q.size()); end
    checks++; if (data !== 8'h5A) begin errors++; $display("FAIL rmid_data2 got %h want 5a", data); end
  endtask
  task automatic test_break();
    clear();
    rx = 0;
    repeat (30 * BIT_CYC) @(negedge clk50);
    checks++; if (fe_cnt != 1) begin errors++; $display("FAIL break_ferr got %0d want 1", fe_cnt); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL break_valid got %0d want 0", got_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_busy got %b want 0", busy); end
    idle(2);
    send_frame(8'h11, 1);
    idle(1);
    checks++; if (!streams_equal()) begin errors++; $display("FAIL break_stream got %0d bytes want %0d", got_q.size(), exp_q.size()); end
    checks++; if (fe_cnt != 1) begin errors++; $display("FAIL break_ferr2 got %0d want 1", fe_cnt); end
    checks++; if (data !== 8'h11) begin errors++; $display("FAIL break_data got %h want 11", data); end
  endtask
  task automatic test_random();
    logic stop;
    clear();
    for (int i = 0; i < 2; i++) begin
      stop = $urandom_range(0, 3) != 0;
      send_frame(8'($urandom), stop);
      idle(stop ? $urandom_range(0, 1) : 1);
    end
    idle(1);
    checks++; if (!streams_equal()) begin errors++; $display("FAIL rand_stream got %0d bytes want %0d", got_q.size(), exp_q.size()); end
    checks++; if (fe_cnt != exp_fe) begin errors++; $display("FAIL rand_ferr got %0d want %0d", fe_cnt, exp_fe); end
    checks++; if (data !== last_good) begin errors++; $display("FAIL rand_data got %h want %h", data, last_good); end
    checks++; if (bad_pulse != 0) begin errors++; $display("FAIL rand_pulse got %0d want 0", bad_pulse); end
  endtask
  initial begin
    test_reset();
    test_good();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid();
    test_break();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
